// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction prefetch buffer.
//   INSTRUCTION_WIDTH / ADDRESS_WIDTH : datapath widths
//   NOP                               : value held by a slot before its word lands
//   fetch_slot_t                      : one queue slot {pc, word, filled}
//   EMPTY_SLOT                        : reset / cleared slot contents
//   word_align()                      : forces an address onto a word boundary
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int ADDRESS_WIDTH     = 32;

    localparam logic [INSTRUCTION_WIDTH-1:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0]     pc;
        logic [INSTRUCTION_WIDTH-1:0] word;
        logic                         filled;
    } fetch_slot_t;

    localparam fetch_slot_t EMPTY_SLOT = '{pc: 32'h0000_0000, word: NOP, filled: 1'b0};

    // Instruction fetches are word granular; the two byte-offset bits are dropped.
    function automatic logic [ADDRESS_WIDTH-1:0] word_align(input logic [ADDRESS_WIDTH-1:0] addr);
        return {addr[ADDRESS_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_slot_queue.sv
// -----------------------------------------------------------------------------
// fetch_slot_queue
// Circular queue of DEPTH fetch slots. A slot is allocated (pc known, word
// pending) when a memory request is accepted, filled in allocation order as
// responses return, and popped from the head once filled.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   alloc_i/_pc_i   : allocate the slot at the alloc pointer with this pc
//   fill_i/_word_i  : write the word into the slot at the fill pointer
//   pop_i           : release the head slot (ignored unless the head is filled)
//   flush_i         : free every slot; has priority over all other operations
//   head_valid_o    : head slot is allocated and filled
//   head_pc_o/word_o: contents of the head slot
//   count_o         : number of allocated slots
//   unfilled_o      : number of allocated slots still waiting for their word
// -----------------------------------------------------------------------------
module fetch_slot_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         alloc_i,
    input  logic [ADDRESS_WIDTH-1:0]     alloc_pc_i,
    input  logic                         fill_i,
    input  logic [INSTRUCTION_WIDTH-1:0] fill_word_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic                         head_valid_o,
    output logic [ADDRESS_WIDTH-1:0]     head_pc_o,
    output logic [INSTRUCTION_WIDTH-1:0] head_word_o,
    output logic [CW-1:0]                count_o,
    output logic [CW-1:0]                unfilled_o
);

    localparam logic [PW-1:0] PTR_STEP  = PW'(1'b1);
    localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    fetch_slot_t   slots_q [DEPTH];
    fetch_slot_t   slots_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] alloc_q, alloc_d;
    logic [PW-1:0] fill_q, fill_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] unfilled_q, unfilled_d;

    logic          head_valid_s;
    logic          pop_s;
    logic          fill_s;
    logic          alloc_s;

    assign head_valid_s = (count_q != CNT_ZERO) && slots_q[head_q].filled;

    // Guard each operation so a misbehaving neighbour cannot corrupt the pointers.
    assign pop_s   = pop_i && head_valid_s;
    assign fill_s  = fill_i && (unfilled_q != CNT_ZERO);
    assign alloc_s = alloc_i && (count_q != CNT_FULL);

    // Next-state for slot contents, pointers and occupancy counters.
    always_comb begin
        slots_d    = slots_q;
        head_d     = head_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        count_d    = count_q;
        unfilled_d = unfilled_q;
        if (flush_i) begin
            head_d     = PTR_ZERO;
            alloc_d    = PTR_ZERO;
            fill_d     = PTR_ZERO;
            count_d    = CNT_ZERO;
            unfilled_d = CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                slots_d[i].filled = 1'b0;
            end
        end else begin
            if (alloc_s) begin
                slots_d[alloc_q] = '{pc: alloc_pc_i, word: NOP, filled: 1'b0};
                alloc_d          = alloc_q + PTR_STEP;
            end else begin
                alloc_d = alloc_q;
            end
            // The fill slot was allocated on an earlier cycle, so it never
            // collides with the slot being allocated now.
            if (fill_s) begin
                slots_d[fill_q].word   = fill_word_i;
                slots_d[fill_q].filled = 1'b1;
                fill_d                 = fill_q + PTR_STEP;
            end else begin
                fill_d = fill_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_STEP;
            end else begin
                head_d = head_q;
            end
            count_d    = count_q + CW'(alloc_s) - CW'(pop_s);
            unfilled_d = unfilled_q + CW'(alloc_s) - CW'(fill_s);
        end
    end

    // Slot array and pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= EMPTY_SLOT;
            end
            head_q     <= PTR_ZERO;
            alloc_q    <= PTR_ZERO;
            fill_q     <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            unfilled_q <= CNT_ZERO;
        end else begin
            slots_q    <= slots_d;
            head_q     <= head_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            count_q    <= count_d;
            unfilled_q <= unfilled_d;
        end
    end

    assign head_valid_o = head_valid_s;
    assign head_pc_o    = slots_q[head_q].pc;
    assign head_word_o  = slots_q[head_q].word;
    assign count_o      = count_q;
    assign unfilled_o   = unfilled_q;

endmodule

// File: rtl/instruction_prefetch_buffer_checker.sv
// -----------------------------------------------------------------------------
// instruction_prefetch_buffer_checker
// Protocol and invariant assertions for the prefetch buffer.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   response_valid_i     : memory response strobe
//   discard_count_i      : responses still owed to flushed fetches
//   unfilled_count_i     : allocated slots awaiting their word
//   slot_count_i         : allocated slots
//   request_address_i    : current fetch address
// -----------------------------------------------------------------------------
module instruction_prefetch_buffer_checker #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk_i,
    input logic          rst_ni,
    input logic          response_valid_i,
    input logic [CW-1:0] discard_count_i,
    input logic [CW-1:0] unfilled_count_i,
    input logic [CW-1:0] slot_count_i,
    input logic [31:0]   request_address_i
);

    logic [CW:0] pending_s;
    logic [CW:0] used_s;

    assign pending_s = {1'b0, discard_count_i} + {1'b0, unfilled_count_i};
    assign used_s    = {1'b0, discard_count_i} + {1'b0, slot_count_i};

    // Every response must answer a fetch that is still outstanding.
    a_response_has_fetch: assert property (@(posedge clk_i) disable iff (!rst_ni)
        response_valid_i |-> (pending_s != {(CW+1){1'b0}}));

    // Credit accounting never exceeds the slot budget.
    a_used_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
        used_s <= (CW+1)'(DEPTH));

    // Fetch addresses stay word aligned.
    a_address_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
        request_address_i[1:0] == 2'b00);

endmodule

// File: rtl/instruction_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// instruction_prefetch_buffer
// Generates sequential word fetches to an in-order, variable-latency
// instruction memory, buffers returned words tagged with their PC, and hands
// them to the fetch stage over a valid/ready handshake. A redirect restarts
// fetch at a new PC and discards everything queued or still in flight.
//   clock, reset (async, active low)
//   memory_request_valid/address/ready : fetch request channel
//   memory_response_valid/data         : in-order response channel
//   instruction_valid/instruction/instruction_pc/instruction_ready : output
//   redirect_valid/redirect_pc         : flush and restart
// -----------------------------------------------------------------------------
module instruction_prefetch_buffer
    import fetch_pkg::*;
#(
    parameter int                       DEPTH    = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         memory_request_valid,
    output logic [ADDRESS_WIDTH-1:0]     memory_request_address,
    input  logic                         memory_request_ready,
    input  logic                         memory_response_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] memory_response_data,
    output logic                         instruction_valid,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [ADDRESS_WIDTH-1:0]     instruction_pc,
    input  logic                         instruction_ready,
    input  logic                         redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0]     redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int UW = CW + 1;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    logic [ADDRESS_WIDTH-1:0]     fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]                discard_q, discard_d;
    logic                         fetch_en_q;

    logic [CW-1:0]                slot_count_s;
    logic [CW-1:0]                unfilled_s;
    logic                         head_valid_s;
    logic [ADDRESS_WIDTH-1:0]     head_pc_s;
    logic [INSTRUCTION_WIDTH-1:0] head_word_s;
    logic [UW-1:0]                used_s;
    logic                         credit_s;
    logic                         req_valid_s;
    logic                         accept_s;
    logic                         drop_s;
    logic                         fill_s;
    logic                         pop_s;

    // Flushed fetches keep consuming credit until their responses come back,
    // so the queue can never be overrun by stale data.
    assign used_s   = UW'(slot_count_s) + UW'(discard_q);
    assign credit_s = used_s < UW'(DEPTH);

    // fetch_en_q holds requests off while reset is asserted.
    assign req_valid_s = fetch_en_q && credit_s && !redirect_valid;
    assign accept_s    = req_valid_s && memory_request_ready;
    assign drop_s      = memory_response_valid && (discard_q != CNT_ZERO);
    assign fill_s      = memory_response_valid && (discard_q == CNT_ZERO) && !redirect_valid;
    assign pop_s       = head_valid_s && instruction_ready && !redirect_valid;

    // Next fetch PC and discard count; redirect overrides everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            // Every fetch still waiting for a word becomes a discard; the
            // response landing this cycle settles one of them immediately.
            discard_d  = discard_q + unfilled_s - CW'(memory_response_valid);
        end else begin
            if (accept_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (drop_s) begin
                discard_d = discard_q - CNT_ONE;
            end else begin
                discard_d = discard_q;
            end
        end
    end

    // Fetch PC, discard count and fetch-enable registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= CNT_ZERO;
            fetch_en_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            fetch_en_q <= 1'b1;
        end
    end

    fetch_slot_queue #(
        .DEPTH (DEPTH)
    ) u_slot_queue (
        .clk_i        (clock),
        .rst_ni       (reset),
        .alloc_i      (accept_s),
        .alloc_pc_i   (fetch_pc_q),
        .fill_i       (fill_s),
        .fill_word_i  (memory_response_data),
        .pop_i        (pop_s),
        .flush_i      (redirect_valid),
        .head_valid_o (head_valid_s),
        .head_pc_o    (head_pc_s),
        .head_word_o  (head_word_s),
        .count_o      (slot_count_s),
        .unfilled_o   (unfilled_s)
    );

    instruction_prefetch_buffer_checker #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_checker (
        .clk_i             (clock),
        .rst_ni            (reset),
        .response_valid_i  (memory_response_valid),
        .discard_count_i   (discard_q),
        .unfilled_count_i  (unfilled_s),
        .slot_count_i      (slot_count_s),
        .request_address_i (fetch_pc_q)
    );

    assign memory_request_valid   = req_valid_s;
    assign memory_request_address = fetch_pc_q;
    assign instruction_valid      = head_valid_s;
    assign instruction            = head_word_s;
    assign instruction_pc         = head_pc_s;

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_instruction_prefetch_buffer
// Randomised bench for instruction_prefetch_buffer. The reference model views
// the design as fetch epochs: every accepted request belongs to the epoch
// current when it was accepted, a redirect opens a new epoch, and only words
// of the current epoch may ever reach the output, in request order.
// -----------------------------------------------------------------------------
module tb_instruction_prefetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic        memory_request_valid;
    logic [31:0] memory_request_address;
    logic        memory_request_ready;
    logic        memory_response_valid;
    logic [31:0] memory_response_data;
    logic        instruction_valid;
    logic [31:0] instruction;
    logic [31:0] instruction_pc;
    logic        instruction_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    instruction_prefetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .memory_request_valid   (memory_request_valid),
        .memory_request_address (memory_request_address),
        .memory_request_ready   (memory_request_ready),
        .memory_response_valid  (memory_response_valid),
        .memory_response_data   (memory_response_data),
        .instruction_valid      (instruction_valid),
        .instruction            (instruction),
        .instruction_pc         (instruction_pc),
        .instruction_ready      (instruction_ready),
        .redirect_valid         (redirect_valid),
        .redirect_pc            (redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- memory + reference model ----------------
    typedef struct {
        logic [31:0] pc;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];     // requests inside memory, oldest first
    logic [31:0] acc_q[$];     // current-epoch PCs accepted and not yet consumed
    int          n_deliv;      // leading entries of acc_q whose word has arrived
    int          cur_epoch;
    logic [31:0] exp_fetch_pc;
    bit          started;      // requests are held off until the first edge after reset
    int          cyc;

    int p_mready = 100;
    int p_iready = 100;
    int p_resp   = 100;
    int p_redir  = 0;
    int lat_min  = 1;
    int lat_max  = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int old_in_flight();
        int n = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch != cur_epoch) n++;
        return n;
    endfunction

    task automatic clear_model();
        mem_q.delete();
        acc_q.delete();
        n_deliv      = 0;
        cur_epoch    = cur_epoch + 1;
        exp_fetch_pc = RESET_PC;
        started      = 1'b0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit redir, input logic [31:0] rpc);
        bit    mready, iready, rsp, exp_rv, exp_iv;
        mreq_t e;
        int    due;

        mready = ($urandom_range(99) < p_mready);
        iready = ($urandom_range(99) < p_iready);
        rsp    = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < p_resp);

        memory_request_ready  = mready;
        instruction_ready     = iready;
        redirect_valid        = redir;
        redirect_pc           = rpc;
        memory_response_valid = rsp;
        memory_response_data  = rsp ? mem_word(mem_q[0].pc) : $urandom();
        #1;

        exp_rv = started && ((old_in_flight() + acc_q.size()) < DEPTH) && !redir;
        exp_iv = (n_deliv > 0);
        check_eq("req_valid", {31'd0, memory_request_valid}, {31'd0, exp_rv});
        check_eq("req_addr", memory_request_address, exp_fetch_pc);
        check_eq("inst_valid", {31'd0, instruction_valid}, {31'd0, exp_iv});
        if (exp_iv) begin
            check_eq("inst_pc", instruction_pc, acc_q[0]);
            check_eq("inst_word", instruction, mem_word(acc_q[0]));
        end

        // Apply what happens at the coming rising edge.
        if (rsp) begin
            e = mem_q.pop_front();
            if ((e.epoch == cur_epoch) && !redir) n_deliv++;
        end
        if (exp_iv && iready) begin
            void'(acc_q.pop_front());
            n_deliv--;
        end
        if (exp_rv && mready) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (mem_q.size() > 0 && mem_q[$].due > due) due = mem_q[$].due;
            mem_q.push_back('{pc: exp_fetch_pc, epoch: cur_epoch, due: due});
            acc_q.push_back(exp_fetch_pc);
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        if (redir) begin
            cur_epoch++;
            acc_q.delete();
            n_deliv      = 0;
            exp_fetch_pc = {rpc[31:2], 2'b00};
        end
        started = 1'b1;
        cyc++;
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step(($urandom_range(99) < p_redir), $urandom());
        end
    endtask

    // Asserts reset at a falling edge, checks the asynchronous effect, releases it.
    task automatic do_reset();
        reset                 = 1'b0;
        memory_request_ready  = 1'b0;
        memory_response_valid = 1'b0;
        memory_response_data  = 32'h0000_0000;
        instruction_ready     = 1'b0;
        redirect_valid        = 1'b0;
        redirect_pc           = 32'h0000_0000;
        #1;
        check_eq("rst_req_valid", {31'd0, memory_request_valid}, 32'd0);
        check_eq("rst_inst_valid", {31'd0, instruction_valid}, 32'd0);
        check_eq("rst_inst", instruction, 32'h0000_0000);
        check_eq("rst_inst_pc", instruction_pc, 32'h0000_0000);
        check_eq("rst_req_addr", memory_request_address, RESET_PC);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        clear_model();
    endtask

    initial begin
        cur_epoch = 0;
        cyc       = 0;
        reset     = 1'b0;
        memory_request_ready  = 1'b0;
        memory_response_valid = 1'b0;
        memory_response_data  = 32'h0000_0000;
        instruction_ready     = 1'b0;
        redirect_valid        = 1'b0;
        redirect_pc           = 32'h0000_0000;
        clear_model();
        @(negedge clock);
        do_reset();

        // Zero-wait memory, everything ready: one instruction per cycle.
        p_mready = 100; p_iready = 100; p_resp = 100; p_redir = 0;
        lat_min = 1; lat_max = 1;
        run(30);

        // Three-cycle latency: credit limits outstanding fetches to DEPTH.
        lat_min = 3; lat_max = 3;
        run(30);

        // Downstream stall from a fresh reset, then drain.
        do_reset();
        p_iready = 0;
        run(12);
        p_iready = 100;
        run(10);

        // Redirect with fetches in flight.
        step(1'b1, 32'h0000_0100);
        run(12);

        // Redirect coinciding with response and pop, then a second redirect.
        lat_min = 1; lat_max = 1;
        run(8);
        step(1'b1, 32'h0000_0180);
        step(1'b1, 32'h0000_0203);
        run(10);

        // Random traffic with random redirects.
        lat_min = 1; lat_max = 4;
        p_mready = 70; p_iready = 60; p_resp = 80; p_redir = 4;
        run(800);

        // Reset in the middle of a burst, then restart.
        p_mready = 100; p_iready = 100; p_resp = 100; p_redir = 0;
        lat_min = 3; lat_max = 3;
        run(10);
        do_reset();
        run(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
